// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and the EX decoder.
//   OP_*    : i_op encodings (MULT, MULTU, DIV, DIVU)
//   ST_*    : 2-bit FSM state encodings
//   abs_val : magnitude of a zero-extended operand, independent of operand width
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  // Caller zero-extends x and supplies its sign; truncating the result back to the
  // operand width yields the two's-complement magnitude (MIN maps to itself, read unsigned).
  function automatic logic [63:0] abs_val(input logic [63:0] x, input logic neg);
    return neg ? (~x + 64'd1) : x;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Pipeline <-> multiply/divide unit bus. Signal names are from the unit's point of view.
//   i_start/i_op/i_data1/i_data2 : launch request and operands
//   i_mthi/i_mtlo                : idle-time HI/LO writes of i_data1
//   o_busy/o_done/o_div_zero     : status
//   o_hi/o_lo                    : architectural HI/LO
// master: EX stage side, slave: multiply/divide unit.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_data1;
  logic [WIDTH-1:0] i_data2;
  logic             i_mthi;
  logic             i_mtlo;
  logic             o_busy;
  logic             o_done;
  logic             o_div_zero;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_op, i_data1, i_data2, i_mthi, i_mtlo,
    input  o_busy, o_done, o_div_zero, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_data1, i_data2, i_mthi, i_mtlo,
    output o_busy, o_done, o_div_zero, o_hi, o_lo
  );

endinterface

// File: rtl/param_adder.sv
// Width-generic adder/subtractor.
//   i_a, i_b : operands
//   i_carry  : 1 = subtract (i_a - i_b), 0 = add (i_a + i_b)
//   o_sum    : result, wraps modulo 2**WIDTH
module param_adder #(
  parameter int unsigned WIDTH = 33
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic [WIDTH-1:0] o_sum
);

  assign o_sum = i_a + (i_b ^ {WIDTH{i_carry}}) + {{(WIDTH-1){1'b0}}, i_carry};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO.
//   i_clk    : clock, all state on rising edge
//   i_rst_n  : synchronous active-low reset
//   io_bus   : slave side of mult_div_unit_if (start/op/operands, MTHI/MTLO, status, HI/LO)
// Operations run on magnitudes for WIDTH cycles, then one FIX cycle applies signs and
// writes HI/LO. A single WIDTH+1-bit adder serves MUL add, DIV subtract and FIX negation.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  mult_div_unit_if.slave  io_bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned AW    = WIDTH + 1;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [AW-1:0]    r_acc;
  logic [WIDTH-1:0] r_mq;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_qmask;
  logic             r_is_div;
  logic             r_neg_hi;
  logic             r_neg_lo;
  logic             r_div_zero;
  logic             r_seen;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_dz;

  logic             w_signed;
  logic             w_is_div;
  logic             w_sgn1;
  logic             w_sgn2;
  logic             w_d2_zero;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic [AW-1:0]    w_add_a;
  logic [AW-1:0]    w_add_b;
  logic             w_add_sub;
  logic [AW-1:0]    w_sum;
  logic [AW-1:0]    w_shift;
  logic             w_borrow;
  logic             w_mul_bit;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  assign w_signed  = (io_bus.i_op == OP_MULT) || (io_bus.i_op == OP_DIV);
  assign w_is_div  = (io_bus.i_op == OP_DIV) || (io_bus.i_op == OP_DIVU);
  assign w_sgn1    = w_signed & io_bus.i_data1[WIDTH-1];
  assign w_sgn2    = w_signed & io_bus.i_data2[WIDTH-1];
  assign w_d2_zero = (io_bus.i_data2 == '0);
  assign w_abs1    = WIDTH'(abs_val(64'(io_bus.i_data1), w_sgn1));
  assign w_abs2    = WIDTH'(abs_val(64'(io_bus.i_data2), w_sgn2));

  assign w_shift  = {r_acc[WIDTH-1:0], r_mq[WIDTH-1]};
  assign w_borrow = w_sum[AW-1];

  // Negative products are negated serially as the low bits retire: bits up to and
  // including the first 1 pass through, later bits are inverted.
  assign w_mul_bit = w_sum[0] ^ (r_neg_lo & r_seen);

  always_comb begin
    w_add_a   = '0;
    w_add_b   = '0;
    w_add_sub = 1'b0;
    case (r_state)
      ST_MUL: begin
        w_add_a = r_acc;
        w_add_b = r_mq[0] ? {1'b0, r_opnd} : '0;
      end
      ST_DIV: begin
        w_add_a   = w_shift;
        w_add_b   = {1'b0, r_opnd};
        w_add_sub = 1'b1;
      end
      ST_FIX: begin
        // Mult high half: ~H + (L==0) == (L!=0 ? -1 : 0) - H. Div: 0 - remainder.
        w_add_a   = (!r_is_div && r_seen) ? '1 : '0;
        w_add_b   = r_acc;
        w_add_sub = 1'b1;
      end
      default: ;
    endcase
  end

  param_adder #(
    .WIDTH (AW)
  ) u_adder (
    .i_a     (w_add_a),
    .i_b     (w_add_b),
    .i_carry (w_add_sub),
    .o_sum   (w_sum)
  );

  // r_qmask marks quotient bits that have a set bit below them; XOR gives -Q.
  assign w_fix_hi = r_neg_hi ? w_sum[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_fix_lo = (r_is_div && r_neg_lo) ? (r_mq ^ r_qmask) : r_mq;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mq       <= '0;
      r_opnd     <= '0;
      r_qmask    <= '0;
      r_is_div   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_neg_lo   <= 1'b0;
      r_div_zero <= 1'b0;
      r_seen     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_dz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (io_bus.i_start) begin
            r_state    <= w_is_div ? ST_DIV : ST_MUL;
            r_cnt      <= CNT_W'(WIDTH);
            r_acc      <= '0;
            r_mq       <= w_is_div ? w_abs1 : w_abs2;
            r_opnd     <= w_is_div ? w_abs2 : w_abs1;
            r_qmask    <= '0;
            r_seen     <= 1'b0;
            r_is_div   <= w_is_div;
            r_div_zero <= w_is_div & w_d2_zero;
            // Remainder follows the dividend; a zero divisor keeps the all-ones quotient.
            r_neg_hi   <= w_is_div ? w_sgn1 : (w_sgn1 ^ w_sgn2);
            r_neg_lo   <= (w_sgn1 ^ w_sgn2) & ~(w_is_div & w_d2_zero);
          end else begin
            if (io_bus.i_mthi) r_hi <= io_bus.i_data1;
            if (io_bus.i_mtlo) r_lo <= io_bus.i_data1;
          end
        end
        ST_MUL: begin
          r_acc  <= {1'b0, w_sum[AW-1:1]};
          r_mq   <= {w_mul_bit, r_mq[WIDTH-1:1]};
          r_seen <= r_seen | w_sum[0];
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= ST_FIX;
        end
        ST_DIV: begin
          r_acc   <= w_borrow ? w_shift : w_sum;
          r_mq    <= {r_mq[WIDTH-2:0], ~w_borrow};
          r_qmask <= w_borrow ? {r_qmask[WIDTH-2:0], 1'b0} : {{(WIDTH-1){1'b1}}, 1'b0};
          r_cnt   <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_dz    <= r_div_zero;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.o_busy     = (r_state != ST_IDLE);
  assign io_bus.o_done     = r_done;
  assign io_bus.o_div_zero = r_dz;
  assign io_bus.o_hi       = r_hi;
  assign io_bus.o_lo       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit at WIDTH=32.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(
    .WIDTH (32)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    bus.i_start = 1'b0;
    bus.i_op    = 2'd0;
    bus.i_data1 = 32'h0;
    bus.i_data2 = 32'h0;
    bus.i_mthi  = 1'b0;
    bus.i_mtlo  = 1'b0;
  endtask

  // Launch at the next edge, then check every busy cycle and the done cycle (34).
  // Returns in the done cycle so the caller may start back-to-back.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz, input bit poke);
    int glitch;
    glitch = 0;
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_data1 = a;
    bus.i_data2 = b;
    tick();
    bus.i_start = 1'b0;
    bus.i_mthi  = 1'b0;
    bus.i_mtlo  = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (poke && c >= 4 && c <= 6) begin
        bus.i_start = 1'b1;
        bus.i_mthi  = 1'b1;
        bus.i_op    = OP_DIV;
        bus.i_data1 = 32'hDEAD0000;
      end else if (poke && c == 7) begin
        clr();
      end
      if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_hi !== m_hi ||
          bus.o_lo !== m_lo || bus.o_div_zero !== 1'b0) glitch++;
      tick();
    end
    chk({tag, " busy window"}, 32'(glitch), 32'd0);
    chk({tag, " done"}, 32'(bus.o_done), 32'd1);
    chk({tag, " busy"}, 32'(bus.o_busy), 32'd0);
    chk({tag, " hi"}, bus.o_hi, exp_hi);
    chk({tag, " lo"}, bus.o_lo, exp_lo);
    chk({tag, " div_zero"}, 32'(bus.o_div_zero), 32'(exp_dz));
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    int glitch;
    clr();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset busy", 32'(bus.o_busy), 32'd0);
    chk("reset done", 32'(bus.o_done), 32'd0);
    chk("reset div_zero", 32'(bus.o_div_zero), 32'd0);
    chk("reset hi", bus.o_hi, 32'h0);
    chk("reset lo", bus.o_lo, 32'h0);
    rst_n = 1'b1;
    tick();

    bus.i_mthi  = 1'b1;
    bus.i_data1 = 32'h0000_1234;
    tick();
    clr();
    chk("mthi hi", bus.o_hi, 32'h0000_1234);
    chk("mthi lo", bus.o_lo, 32'h0);
    chk("mthi done", 32'(bus.o_done), 32'd0);
    m_hi = 32'h0000_1234;

    bus.i_mthi  = 1'b1;
    bus.i_mtlo  = 1'b1;
    bus.i_data1 = 32'hA5A5_0F0F;
    tick();
    clr();
    chk("mthi+mtlo hi", bus.o_hi, 32'hA5A5_0F0F);
    chk("mthi+mtlo lo", bus.o_lo, 32'hA5A5_0F0F);
    m_hi = 32'hA5A5_0F0F;
    m_lo = 32'hA5A5_0F0F;

    // i_mthi alongside i_start: the start wins, HI is untouched until FIX.
    bus.i_mthi = 1'b1;
    run_op("mult -1x2", OP_MULT, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
    tick();
    chk("mult done pulse", 32'(bus.o_done), 32'd0);

    run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
    tick();
    run_op("mult min*min", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,
           1'b0, 1'b0);
    tick();

    run_op("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("divu 7/2 b2b", OP_DIVU, 32'h7, 32'h2, 32'h1, 32'h3, 1'b0, 1'b0);
    tick();
    chk("b2b done pulse", 32'(bus.o_done), 32'd0);

    run_op("divu 7/0", OP_DIVU, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF, 1'b1, 1'b0);
    tick();
    chk("div_zero pulse", 32'(bus.o_div_zero), 32'd0);
    run_op("div -7/0", OP_DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0);
    tick();
    run_op("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 1'b0);
    tick();

    run_op("mult -3x7 poke", OP_MULT, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB,
           1'b0, 1'b1);
    tick();
    chk("no queued start", 32'(bus.o_busy), 32'd0);

    // Reset during iteration 10 of a divide.
    bus.i_start = 1'b1;
    bus.i_op    = OP_DIV;
    bus.i_data1 = 32'd100;
    bus.i_data2 = 32'd3;
    tick();
    clr();
    repeat (9) tick();
    chk("div in flight", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midop rst busy", 32'(bus.o_busy), 32'd0);
    chk("midop rst hi", bus.o_hi, 32'h0);
    chk("midop rst lo", bus.o_lo, 32'h0);
    chk("midop rst done", 32'(bus.o_done), 32'd0);
    m_hi = 32'h0;
    m_lo = 32'h0;
    glitch = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) glitch++;
      tick();
    end
    chk("discarded op silent", 32'(glitch), 32'd0);

    run_op("multu 3x5", OP_MULTU, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
